// File: rtl/mmu_wrr_dma_scheduler.sv
// Weighted round-robin arbiter sharing one DMA request channel among N_REQ MMU regions,
// with a parallel {id,len} ordering record. Define WRR_STATS_EN for per-region grant counters.
module mmu_wrr_dma_scheduler #(
  parameter int N_REQ    = 4,
  parameter int REQ_BITS = 128,
  parameter int LEN_BITS = 28,
  parameter int WGT_BITS = 4,
  localparam int ID_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_REQ*WGT_BITS-1:0]     cfg_weight,
  input  logic [N_REQ-1:0]              s_req_valid,
  output logic [N_REQ-1:0]              s_req_ready,
  input  logic [N_REQ*REQ_BITS-1:0]     s_req_data,
  input  logic [N_REQ*LEN_BITS-1:0]     s_req_len,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic [REQ_BITS-1:0]           m_req_data,
  output logic                          m_mux_valid,
  input  logic                          m_mux_ready,
  output logic [ID_BITS+LEN_BITS-1:0]   m_mux_data
`ifdef WRR_STATS_EN
  ,
  output logic [N_REQ*32-1:0]           stat_grants
`endif
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t                       state_q, state_d;
  logic [ID_BITS-1:0]           cur_q, cur_d;
  logic [WGT_BITS-1:0]          credit_q, credit_d;
  logic                         req_vld_q, req_vld_d;
  logic                         mux_vld_q, mux_vld_d;
  logic [REQ_BITS-1:0]          req_data_q, req_data_d;
  logic [ID_BITS+LEN_BITS-1:0]  mux_data_q, mux_data_d;

  logic [ID_BITS-1:0]           scan_g, grant_g, cand;
  logic [WGT_BITS-1:0]          wgt_g;
  logic                         found, keep, slot_free, grant;

  // Slot is reusable when every set flag is being consumed this cycle.
  assign slot_free = (!req_vld_q || m_req_ready) && (!mux_vld_q || m_mux_ready);
  assign keep      = s_req_valid[cur_q] && (credit_q != '0);
  assign grant     = aresetn && slot_free && (|s_req_valid);
  assign grant_g   = keep ? cur_q : scan_g;
  assign wgt_g     = cfg_weight[int'(grant_g)*WGT_BITS +: WGT_BITS];

  always_comb begin
    found  = 1'b0;
    scan_g = '0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_BITS'((int'(cur_q) + i) % N_REQ);
      if (!found && s_req_valid[cand]) begin
        found  = 1'b1;
        scan_g = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    credit_d    = credit_q;
    req_vld_d   = req_vld_q && !m_req_ready;
    mux_vld_d   = mux_vld_q && !m_mux_ready;
    req_data_d  = req_data_q;
    mux_data_d  = mux_data_q;
    s_req_ready = '0;

    unique case (state_q)
      ARB:  state_d = grant ? HOLD : ARB;
      HOLD: state_d = grant ? HOLD : (slot_free ? ARB : HOLD);
      default: state_d = ARB;
    endcase

    if (grant) begin
      s_req_ready[grant_g] = 1'b1;
      req_vld_d  = 1'b1;
      mux_vld_d  = 1'b1;
      req_data_d = s_req_data[int'(grant_g)*REQ_BITS +: REQ_BITS];
      mux_data_d = {grant_g, s_req_len[int'(grant_g)*LEN_BITS +: LEN_BITS]};
      cur_d      = grant_g;
      // A fresh quantum spends one unit of its weight on this grant; weight 0 acts as 1.
      if (keep)
        credit_d = credit_q - 1'b1;
      else if (wgt_g == '0)
        credit_d = '0;
      else
        credit_d = wgt_g - 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ARB;
      cur_q      <= '0;
      credit_q   <= '0;
      req_vld_q  <= 1'b0;
      mux_vld_q  <= 1'b0;
      req_data_q <= '0;
      mux_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      credit_q   <= credit_d;
      req_vld_q  <= req_vld_d;
      mux_vld_q  <= mux_vld_d;
      req_data_q <= req_data_d;
      mux_data_q <= mux_data_d;
    end
  end

  assign m_req_valid = req_vld_q;
  assign m_mux_valid = mux_vld_q;
  assign m_req_data  = req_data_q;
  assign m_mux_data  = mux_data_q;

`ifdef WRR_STATS_EN
  logic [31:0] grants_q [N_REQ];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < N_REQ; r++) grants_q[r] <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++)
        if (s_req_valid[r] && s_req_ready[r] && (grants_q[r] != '1))
          grants_q[r] <= grants_q[r] + 32'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int r = 0; r < N_REQ; r++) stat_grants[r*32 +: 32] = grants_q[r];
  end
`endif

endmodule
